// File: rtl/para_pipe_reg.sv
// Elastic DEPTH-stage pipeline register with valid/ready handshake, bubble collapsing,
// synchronous flush and occupancy count. Define PARA_PIPE_PARITY_EN for per-stage parity.
module para_pipe_reg #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  input  logic          out_ready,
  output logic [CW-1:0] count,
  output logic          parity_err
);

  logic [DEPTH-1:0]        valid_q;
  logic [DEPTH-1:0][W-1:0] data_q;
  logic [CW-1:0]           count_q;

  logic [DEPTH:0]          rdy;
  logic [DEPTH-1:0]        load_v;
  logic [DEPTH-1:0][W-1:0] load_d;
  logic                    accept;
  logic                    emit;

  // A stage is ready when empty or when everything downstream of it moves.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy[i] = ~valid_q[i] | rdy[i+1];
    end
  end

  assign in_ready  = rdy[0] & ~flush;
  assign accept    = in_valid & in_ready;
  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign emit      = out_valid & out_ready;
  assign count     = count_q;

  always_comb begin
    load_v    = '0;
    load_d    = '0;
    load_v[0] = accept;
    load_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      load_v[i] = valid_q[i-1];
      load_d[i] = data_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      // Data registers keep their contents; only the valid bits are dropped.
      valid_q <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i]) begin
          valid_q[i] <= load_v[i];
          if (load_v[i]) data_q[i] <= load_d[i];
        end
      end
      if (accept && !emit) begin
        count_q <= count_q + CW'(1);
      end else if (emit && !accept) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

`ifdef PARA_PIPE_PARITY_EN
  logic [DEPTH-1:0] par_q;
  logic [DEPTH-1:0] load_p;
  logic             parity_err_q;

  always_comb begin
    load_p    = '0;
    load_p[0] = ^in_data;
    for (int i = 1; i < DEPTH; i++) begin
      load_p[i] = par_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q        <= '0;
      parity_err_q <= 1'b0;
    end else if (flush) begin
      parity_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i] && load_v[i]) par_q[i] <= load_p[i];
      end
      if (emit) parity_err_q <= (^out_data) != par_q[DEPTH-1];
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
